// File: rtl/hall_call_registry.sv
// Hall call registry: latches per-floor up/down hall calls, drives the lamps and
// offers undispatched calls round-robin to the building controller over valid/ack.
module hall_call_registry #(
    parameter int FLOOR_COUNT = 7,
    parameter int FLOOR_W     = 3,
    parameter int CNT_W       = 4
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic [FLOOR_COUNT-1:0] up_button,
    input  logic [FLOOR_COUNT-1:0] down_button,
    input  logic                   served_valid,
    input  logic [FLOOR_W-1:0]     served_floor,
    input  logic                   served_dir,
    output logic [FLOOR_W:0]       hall_request,
    output logic                   request_valid,
    input  logic                   request_ack,
    output logic [FLOOR_COUNT-1:0] up_lamp,
    output logic [FLOOR_COUNT-1:0] down_lamp,
    output logic [CNT_W-1:0]       pending_count
);
    localparam int NS = 2 ** (FLOOR_W + 1);
    // No up call exists at the top floor, no down call at the bottom floor.
    localparam logic [FLOOR_COUNT-1:0] UP_MASK = {1'b0, {(FLOOR_COUNT-1){1'b1}}};
    localparam logic [FLOOR_COUNT-1:0] DN_MASK = {{(FLOOR_COUNT-1){1'b1}}, 1'b0};

    typedef enum logic {IDLE, OFFER} state_t;

    state_t                 state_q;
    logic [FLOOR_W:0]       hall_req_q, ptr_q;
    logic                   req_valid_q;
    logic [FLOOR_COUNT-1:0] up_pend_q, up_pend_d, dn_pend_q, dn_pend_d;
    logic [FLOOR_COUNT-1:0] up_disp_q, up_disp_d, dn_disp_q, dn_disp_d;
    logic [FLOOR_COUNT-1:0] up_clr, dn_clr;
    logic [CNT_W-1:0]       cnt_q, cnt_d;
    logic [NS-1:0]          cand;
    logic [FLOOR_W:0]       idx, pick_slot;
    logic                   found, serve_ok, offer_served, accept;

    always_comb begin
        serve_ok     = served_valid && (32'(served_floor) < FLOOR_COUNT);
        offer_served = serve_ok && ({served_dir, served_floor} == hall_req_q);
        accept       = (state_q == OFFER) && request_ack && !offer_served;

        up_clr = '0;
        dn_clr = '0;
        for (int f = 0; f < FLOOR_COUNT; f++) begin
            if (serve_ok && served_floor == FLOOR_W'(f)) begin
                if (served_dir) up_clr[f] = 1'b1;
                else            dn_clr[f] = 1'b1;
            end
        end

        // Service is applied after the press so a same-cycle press is dropped.
        up_pend_d = (up_pend_q | (up_button & UP_MASK)) & ~up_clr;
        dn_pend_d = (dn_pend_q | (down_button & DN_MASK)) & ~dn_clr;
        up_disp_d = up_disp_q & ~up_clr;
        dn_disp_d = dn_disp_q & ~dn_clr;
        for (int f = 0; f < FLOOR_COUNT; f++) begin
            if (accept && hall_req_q[FLOOR_W-1:0] == FLOOR_W'(f)) begin
                if (hall_req_q[FLOOR_W]) up_disp_d[f] = 1'b1;
                else                     dn_disp_d[f] = 1'b1;
            end
        end

        cand = '0;
        for (int f = 0; f < FLOOR_COUNT; f++) begin
            cand[f]        = dn_pend_q[f] & ~dn_disp_q[f];
            cand[NS/2 + f] = up_pend_q[f] & ~up_disp_q[f];
        end

        // Search starts just past the pointer; the pointer slot itself is tried last.
        found     = 1'b0;
        pick_slot = '0;
        idx       = '0;
        for (int k = 1; k <= NS; k++) begin
            idx = ptr_q + (FLOOR_W+1)'(k);
            if (!found && cand[idx]) begin
                found     = 1'b1;
                pick_slot = idx;
            end
        end

        cnt_d = '0;
        for (int f = 0; f < FLOOR_COUNT; f++) begin
            cnt_d = cnt_d + CNT_W'(up_pend_d[f]) + CNT_W'(dn_pend_d[f]);
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            up_pend_q <= '0;
            dn_pend_q <= '0;
            up_disp_q <= '0;
            dn_disp_q <= '0;
            cnt_q     <= '0;
        end else begin
            up_pend_q <= up_pend_d;
            dn_pend_q <= dn_pend_d;
            up_disp_q <= up_disp_d;
            dn_disp_q <= dn_disp_d;
            cnt_q     <= cnt_d;
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q     <= IDLE;
            hall_req_q  <= '0;
            req_valid_q <= 1'b0;
            ptr_q       <= '0;
        end else begin
            unique case (state_q)
                IDLE: begin
                    if (found) begin
                        hall_req_q  <= pick_slot;
                        req_valid_q <= 1'b1;
                        state_q     <= OFFER;
                    end
                end
                OFFER: begin
                    if (offer_served) begin
                        req_valid_q <= 1'b0;
                        state_q     <= IDLE;
                    end else if (request_ack) begin
                        ptr_q       <= hall_req_q;
                        req_valid_q <= 1'b0;
                        state_q     <= IDLE;
                    end
                end
            endcase
        end
    end

    assign hall_request  = hall_req_q;
    assign request_valid = req_valid_q;
    assign up_lamp       = up_pend_q;
    assign down_lamp     = dn_pend_q;
    assign pending_count = cnt_q;
endmodule
